// File: rtl/instruction_loader_if.sv
// Byte-stream in / instruction-memory write port out, bundled for the loader.
// Latency: n/a (signal bundle only).
// Backpressure: none; the byte source cannot be stalled, the loader takes one byte per cycle.
// Ports: master = byte source / memory side (drives i_*), slave = loader (drives o_*).
interface instruction_loader_if;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_write_instruction_flag;
  logic [31:0] o_instruction_to_write;
  logic [31:0] o_address_to_write_inst;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_write_instruction_flag, o_instruction_to_write, o_address_to_write_inst,
    input  o_busy, o_done, o_error
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_write_instruction_flag, o_instruction_to_write, o_address_to_write_inst,
    output o_busy, o_done, o_error
  );
endinterface

// File: rtl/instruction_loader.sv
// Assembles big-endian 32-bit words from a byte stream and writes them to instruction memory.
// Latency: write flag registered on the edge that accepts the 4th byte, high for one cycle.
// Backpressure: none; one byte per cycle sustained, a byte in the write cycle starts the next word.
// Ports: i_clk, i_reset (sync, active-high); bus.slave carries start, rx byte/strobe,
//        write flag/word/address, and busy/done/error status.
module instruction_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  instruction_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                  state;
  logic [1:0]              byte_cnt;
  logic [23:0]             word_lo;   // last three bytes; the 4th completes the word
  logic [ADDR_WIDTH-1:0]   addr;      // address of the word being assembled
  logic [ADDR_WIDTH-1:0]   wr_addr;   // held copy presented on the write port
  logic                    wr_flag;
  logic [31:0]             wr_word;
  logic                    busy;
  logic                    done;
  logic                    error;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      word_lo  <= 24'd0;
      addr     <= '0;
      wr_addr  <= '0;
      wr_flag  <= 1'b0;
      wr_word  <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_flag <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.i_start) begin
            state    <= LOAD;
            byte_cnt <= 2'd0;
            word_lo  <= 24'd0;
            addr     <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        LOAD: begin
          // The cycle after a write decides whether the session ends.
          if (wr_flag) begin
            if (wr_word == HALT_WORD) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (addr == LAST_ADDR) begin
              state <= ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              addr <= addr + ADDR_WIDTH'(4);
            end
          end
          // Byte count is 0 during a write cycle, so a byte here is byte 0 of the
          // next word and can never retrigger a write. If the session ends this
          // cycle the shifted byte is harmless: start clears the assembly state.
          if (bus.i_rx_valid) begin
            word_lo  <= {word_lo[15:0], bus.i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_flag <= 1'b1;
              wr_word <= {word_lo, bus.i_rx_data};
              wr_addr <= addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_write_instruction_flag = wr_flag;
  assign bus.o_instruction_to_write   = wr_word;
  assign bus.o_address_to_write_inst  = {{(32-ADDR_WIDTH){1'b0}}, wr_addr};
  assign bus.o_busy                   = busy;
  assign bus.o_done                   = done;
  assign bus.o_error                  = error;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } wr_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] exp_addr;
    logic        exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wr_cnt_a = 0;
  int   wr_cnt_b = 0;
  logic prev_flag_a = 1'b0;
  logic prev_flag_b = 1'b0;
  wr_t  exp_a[$];
  wr_t  exp_b[$];
  int   flag_cyc_a[$];

  instruction_loader_if bus_a();
  instruction_loader_if bus_b();

  instruction_loader #(.ADDR_WIDTH(12), .HALT_WORD(32'hFFFF_FFFF)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(bus_a.slave)
  );
  instruction_loader #(.ADDR_WIDTH(4), .HALT_WORD(32'hFFFF_FFFF)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write-port monitors: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus_a.o_write_instruction_flag === 1'b1) begin
      wr_cnt_a++;
      flag_cyc_a.push_back(cyc);
      check("flag_gap_a", {31'd0, prev_flag_a}, 32'd0);
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write_a: data %h addr %h, none expected",
                 bus_a.o_instruction_to_write, bus_a.o_address_to_write_inst);
      end else begin
        wr_t e;
        e = exp_a.pop_front();
        check("wr_data_a", bus_a.o_instruction_to_write, e.data);
        check("wr_addr_a", bus_a.o_address_to_write_inst, e.addr);
      end
    end
    prev_flag_a = bus_a.o_write_instruction_flag;
  end

  always @(negedge clk) begin
    if (bus_b.o_write_instruction_flag === 1'b1) begin
      wr_cnt_b++;
      check("flag_gap_b", {31'd0, prev_flag_b}, 32'd0);
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write_b: data %h addr %h, none expected",
                 bus_b.o_instruction_to_write, bus_b.o_address_to_write_inst);
      end else begin
        wr_t e;
        e = exp_b.pop_front();
        check("wr_data_b", bus_b.o_instruction_to_write, e.data);
        check("wr_addr_b", bus_b.o_address_to_write_inst, e.addr);
      end
    end
    prev_flag_b = bus_b.o_write_instruction_flag;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte_a(input logic [7:0] b);
    bus_a.i_rx_data = b; bus_a.i_rx_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.i_rx_valid = 1'b0;
  endtask

  task automatic send_byte_b(input logic [7:0] b);
    bus_b.i_rx_data = b; bus_b.i_rx_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.i_rx_valid = 1'b0;
  endtask

  task automatic send_word_a(input logic [31:0] w, input logic [31:0] a, input bit expect_wr);
    wr_t e;
    e.data = w; e.addr = a;
    if (expect_wr) exp_a.push_back(e);
    for (int i = 0; i < 4; i++) send_byte_a(w[31-8*i -: 8]);
  endtask

  task automatic send_word_b(input logic [31:0] w, input logic [31:0] a, input bit expect_wr);
    wr_t e;
    e.data = w; e.addr = a;
    if (expect_wr) exp_b.push_back(e);
    for (int i = 0; i < 4; i++) send_byte_b(w[31-8*i -: 8]);
  endtask

  task automatic start_a();
    bus_a.i_start = 1'b1; @(posedge clk); #1; bus_a.i_start = 1'b0;
  endtask

  task automatic start_b();
    bus_b.i_start = 1'b1; @(posedge clk); #1; bus_b.i_start = 1'b0;
  endtask

  initial begin
    vec_t vecs[3];
    int   n0;
    vecs[0] = '{word: 32'h2001_0005, exp_addr: 32'd0, exp_done: 1'b0};
    vecs[1] = '{word: 32'h0000_0000, exp_addr: 32'd4, exp_done: 1'b0};
    vecs[2] = '{word: 32'hFFFF_FFFF, exp_addr: 32'd8, exp_done: 1'b1};

    bus_a.i_start = 1'b0; bus_a.i_rx_data = 8'h00; bus_a.i_rx_valid = 1'b0;
    bus_b.i_start = 1'b0; bus_b.i_rx_data = 8'h00; bus_b.i_rx_valid = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_flag",  {31'd0, bus_a.o_write_instruction_flag}, 32'd0);
    check("rst_instr", bus_a.o_instruction_to_write, 32'd0);
    check("rst_addr",  bus_a.o_address_to_write_inst, 32'd0);
    check("rst_busy",  {31'd0, bus_a.o_busy}, 32'd0);
    check("rst_done",  {31'd0, bus_a.o_done}, 32'd0);
    check("rst_error", {31'd0, bus_a.o_error}, 32'd0);

    // Bytes without start are ignored
    send_word_a(32'h1234_5678, 32'd0, 1'b0);
    tick(2);
    @(negedge clk);
    check("idle_no_write", wr_cnt_a, 32'd0);
    check("idle_busy", {31'd0, bus_a.o_busy}, 32'd0);

    // Normal load, table-driven, one idle cycle between words
    start_a();
    @(negedge clk);
    check("start_busy", {31'd0, bus_a.o_busy}, 32'd1);
    foreach (vecs[i]) begin
      send_word_a(vecs[i].word, vecs[i].exp_addr, 1'b1);
      @(negedge clk);  // write cycle
      check("done_in_wr_cycle", {31'd0, bus_a.o_done}, 32'd0);
      @(negedge clk);  // cycle after the write
      check("done_after_word", {31'd0, bus_a.o_done}, {31'd0, vecs[i].exp_done});
      check("busy_after_word", {31'd0, bus_a.o_busy}, {31'd0, ~vecs[i].exp_done});
    end
    check("normal_writes", wr_cnt_a, 32'd3);

    // Reload after DONE with halt-only data
    start_a();
    @(negedge clk);
    check("reload_done_clr", {31'd0, bus_a.o_done}, 32'd0);
    send_word_a(32'hFFFF_FFFF, 32'd0, 1'b1);
    tick(1);
    @(negedge clk);
    check("reload_done", {31'd0, bus_a.o_done}, 32'd1);

    // Back-to-back: 12 bytes on 12 consecutive cycles
    start_a();
    flag_cyc_a.delete();
    send_word_a(32'h1122_3344, 32'd0, 1'b1);
    send_word_a(32'h5566_7788, 32'd4, 1'b1);
    send_word_a(32'h99AA_BBCC, 32'd8, 1'b1);
    tick(2);
    @(negedge clk);
    check("b2b_pulses", flag_cyc_a.size(), 32'd3);
    if (flag_cyc_a.size() == 3) begin
      check("b2b_gap1", flag_cyc_a[1] - flag_cyc_a[0], 32'd4);
      check("b2b_gap2", flag_cyc_a[2] - flag_cyc_a[1], 32'd4);
    end
    check("b2b_busy", {31'd0, bus_a.o_busy}, 32'd1);

    // Reset mid-word: two stale bytes must not leak into the next word
    send_byte_a(8'h12);
    send_byte_a(8'h34);
    rst = 1'b1; tick(1); rst = 1'b0;
    @(negedge clk);
    check("midrst_flag", {31'd0, bus_a.o_write_instruction_flag}, 32'd0);
    check("midrst_busy", {31'd0, bus_a.o_busy}, 32'd0);
    n0 = wr_cnt_a;
    start_a();
    send_word_a(32'hAABB_CCDD, 32'd0, 1'b1);
    tick(2);
    @(negedge clk);
    check("midrst_one_write", wr_cnt_a - n0, 32'd1);

    // Overflow on the 16-byte instance: 4 non-halt words fill memory
    start_b();
    send_word_b(32'h0101_0101, 32'd0,  1'b1);
    send_word_b(32'h0202_0202, 32'd4,  1'b1);
    send_word_b(32'h0303_0303, 32'd8,  1'b1);
    send_word_b(32'h0404_0404, 32'd12, 1'b1);
    @(negedge clk);
    check("ovf_err_in_wr_cycle", {31'd0, bus_b.o_error}, 32'd0);
    @(negedge clk);
    check("ovf_error", {31'd0, bus_b.o_error}, 32'd1);
    check("ovf_busy",  {31'd0, bus_b.o_busy}, 32'd0);
    check("ovf_done",  {31'd0, bus_b.o_done}, 32'd0);
    send_word_b(32'h0505_0505, 32'd0, 1'b0);
    tick(2);
    @(negedge clk);
    check("ovf_no_more_writes", wr_cnt_b, 32'd4);
    check("ovf_error_sticky", {31'd0, bus_b.o_error}, 32'd1);
    start_b();
    @(negedge clk);
    check("ovf_restart_err", {31'd0, bus_b.o_error}, 32'd0);
    check("ovf_restart_busy", {31'd0, bus_b.o_busy}, 32'd1);
    send_word_b(32'hDEAD_BEEF, 32'd0, 1'b1);
    tick(2);
    @(negedge clk);
    check("ovf_restart_write", wr_cnt_b, 32'd5);

    check("sb_a_empty", exp_a.size(), 32'd0);
    check("sb_b_empty", exp_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Loads a program into instruction memory from a byte stream, typically the UART receiver used by the debug unit. It assembles bytes into 32-bit big-endian instruction words and drives the instruction-memory write port of the fetch stage: write flag, instruction word and byte address. Words are written at consecutive word-aligned addresses starting at 0. Loading ends when the halt instruction has been written, or with an error when memory fills first.

## Interface
- ADDR_WIDTH, 12, byte-address width of instruction memory; capacity is 2^ADDR_WIDTH/4 words.
- HALT_WORD, 32'hFFFF_FFFF, encoding of the halt instruction; it terminates a load.

- i_clk  in  1  single clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a load session.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data is valid this cycle.
- o_write_instruction_flag  out  1  write enable to instruction memory.
- o_instruction_to_write  out  32  assembled instruction word.
- o_address_to_write_inst  out  32  byte address of the write; zero-extended from ADDR_WIDTH, bits [1:0] always 0.
- o_busy  out  1  high while in LOAD.
- o_done  out  1  sticky: program loaded, halt word written.
- o_error  out  1  sticky: memory full before halt word.

## Operation
- States: IDLE, LOAD, DONE, ERROR. Reset goes to IDLE; all outputs are 0; byte count, word assembly register and address are cleared.
- From IDLE, DONE or ERROR, i_start goes to LOAD. Entering LOAD clears the address to 0, the byte count to 0, o_done and o_error. i_start while in LOAD is ignored.
- In LOAD, each i_rx_valid shifts in one byte: word <= {word[23:0], i_rx_data}, and the byte count is incremented modulo 4. The first byte received becomes bits [31:24].
- When the 4th byte of a word is accepted, at edge N:
  - o_instruction_to_write = {word[23:0], i_rx_data}.
  - o_address_to_write_inst = current address.
  - o_write_instruction_flag = 1 for exactly one cycle, N to N+1.
- At edge N+1:
  - If the word equals HALT_WORD, go to DONE.
  - Else, if the address equals 2^ADDR_WIDTH-4 (last word), go to ERROR.
  - Otherwise add 4 to the address and stay in LOAD.
- A byte arriving in the write cycle (N to N+1) is accepted normally as byte 0 of the next word.
- i_rx_valid in IDLE, DONE or ERROR is ignored, with no state change.
- o_instruction_to_write and o_address_to_write_inst hold their last values when the flag is low.
- o_busy = (state == LOAD).
- o_done is high only in DONE; o_error is high only in ERROR. Both stay high until i_start or reset.
- A partial word (1–3 bytes) is discarded by reset or by any return to IDLE. Reset mid-load leaves no pending write and the flag low on the next cycle.

## Timing
- i_start at edge S: o_busy = 1 from S; the first byte is acceptable in the cycle after S.
- Latency from the 4th byte's valid cycle to the write flag: flag registered at the same edge, high for the following cycle.
- Halt word: flag high in cycle N, then o_done = 1 and o_busy = 0 from edge N+1.
- Sustained rate: one byte per cycle; back-to-back strobes lose no bytes and produce one write every 4 cycles.
- The write flag is never high on two consecutive cycles.

## Test plan
- Reset: after reset, all outputs are 0 and state is IDLE. Bytes sent without i_start produce no write.
- Normal load: i_start, then bytes 20 01 00 05, 00 00 00 00, FF FF FF FF.
  - Writes: 0x20010005 at address 0, 0x00000000 at address 4, 0xFFFFFFFF at address 8.
  - o_done rises the cycle after the third write; o_busy is then 0.
- Back-to-back: 12 bytes on 12 consecutive cycles.
  - Exactly 3 single-cycle write pulses, 4 cycles apart.
  - Byte order is correct; no byte is dropped in a write cycle.
- Overflow with ADDR_WIDTH=4: 4 non-halt words.
  - Writes at addresses 0, 4, 8, 12.
  - o_error = 1 after the 4th write; further bytes produce no writes.
  - i_start then restarts the load at address 0 and clears o_error.
- Reset mid-word: 2 bytes, then reset, then i_start and a full word 0xAABBCCDD.
  - Single write of 0xAABBCCDD at address 0; no stale bytes in the word.
- Reload after DONE: a second i_start plus halt-only data.
  - o_done drops on start; halt word written at address 0; o_done rises again.
